// File: rtl/piso_register4_tx_pkg.sv
// Shared definitions for the 4-bit PISO transmitter.
// Define PISO_PARITY_EN to append an even-parity bit (PAR state) to each frame.
package piso_register4_tx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PISO_PARITY_EN
    PAR   = 2'd2,
`endif
    SHIFT = 2'd1
  } state_t;

  function automatic logic even_parity(input logic [DEFAULT_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/piso_register4_tx_ctrl.sv
// Frame sequencer: FSM plus bit counter, emitting load/shift/frame/done controls.
// The PAR state and par_en output exist only when PISO_PARITY_EN is defined.
module piso_ctrl
  import piso_register4_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_valid,
  output logic load_ready,
  output logic load_en,
  output logic shift_en,
  output logic frame,
`ifdef PISO_PARITY_EN
  output logic par_en,
`endif
  output logic done_set
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign load_ready = (state == IDLE) & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    frame     = 1'b0;
    done_set  = 1'b0;
`ifdef PISO_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          load_en   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Counter stops at WIDTH; the terminal cycle hands off to PAR or finishes.
        if (cnt != CW'(WIDTH)) begin
          shift_en = 1'b1;
          frame    = 1'b1;
          cnt_nxt  = cnt + 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          par_en    = 1'b1;
          frame     = 1'b1;
          state_nxt = PAR;
`else
          done_set  = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        done_set  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/piso_register4_tx.sv
// Parallel-in/serial-out transmitter: shift register, parity, registered outputs.
// Define PISO_PARITY_EN to send an even-parity bit after the data bits.
module piso_register4_tx
  import piso_register4_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WIDTH:1] i,
  input  logic           load_valid,
  output logic           load_ready,
  output logic           sout,
  output logic           sframe,
  output logic           done
);

  logic [WIDTH:1] sreg;
  logic           head;
  logic           sout_nxt;
  logic           load_en, shift_en, frame, done_set;
`ifdef PISO_PARITY_EN
  logic           par_en;
  logic           par_q;
`endif

  piso_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_en    (load_en),
    .shift_en   (shift_en),
    .frame      (frame),
`ifdef PISO_PARITY_EN
    .par_en     (par_en),
`endif
    .done_set   (done_set)
  );

  assign head = MSB_FIRST ? sreg[WIDTH] : sreg[1];

  always_comb begin
    sout_nxt = 1'b0;
    if (shift_en) sout_nxt = head;
`ifdef PISO_PARITY_EN
    else if (par_en) sout_nxt = par_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (load_en)
        sreg <= i;
      else if (shift_en)
        sreg <= MSB_FIRST ? {sreg[WIDTH-1:1], 1'b0} : {1'b0, sreg[WIDTH:2]};
      sout   <= sout_nxt;
      sframe <= frame;
      done   <= done_set;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is taken from the word as captured, since the shift register is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_q <= 1'b0;
    else if (load_en) par_q <= ^i;
  end
`endif

endmodule

// File: tb/tb_piso_register4_tx.sv
// Bench for piso_register4_tx: MSB-first and LSB-first instances checked against a frame-queue model.
module tb_piso_register4_tx;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int FL = W + PEN;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W:1]   i = '0;
  logic         load_valid = 1'b0;
  logic         ready_m, sout_m, sframe_m, done_m;
  logic         ready_l, sout_l, sframe_l, done_l;
  logic [7:0]   obs_v, exp_v;
  logic [5:0]   q[$];
  logic         mdl_ready = 1'b0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  piso_register4_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .i(i), .load_valid(load_valid),
    .load_ready(ready_m), .sout(sout_m), .sframe(sframe_m), .done(done_m));

  piso_register4_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .i(i), .load_valid(load_valid),
    .load_ready(ready_l), .sout(sout_l), .sframe(sframe_l), .done(done_l));

  assign obs_v = {sout_m, sframe_m, done_m, sout_l, sframe_l, done_l, ready_m, ready_l};

  // Expected per-cycle entries {sout,sframe,done} for MSB then LSB instance.
  function automatic void push_frame(input logic [W-1:0] w);
    logic bm, bl, p;
    q.push_back(6'b000000);
    for (int k = 1; k <= W; k++) begin
      bm = 1'((w >> (W - k)) & 1);
      bl = 1'((w >> (k - 1)) & 1);
      q.push_back({bm, 1'b1, 1'b0, bl, 1'b1, 1'b0});
    end
    if (PEN == 1) begin
      p = 1'($countones(w) % 2);
      q.push_back({p, 1'b1, 1'b0, p, 1'b1, 1'b0});
    end
    q.push_back(6'b001001);
  endfunction

  task automatic drive(input logic lv, input logic [W-1:0] w);
    load_valid = lv;
    i = w;
  endtask

  task automatic step();
    logic lv_s, rdy_s;
    logic [W-1:0] w_s;
    logic [5:0] ent;
    lv_s = load_valid; w_s = i; rdy_s = mdl_ready;
    @(posedge clk); #1;
    if (lv_s && rdy_s) push_frame(w_s);
    if (q.size() == 0) begin
      ent = 6'b0; mdl_ready = 1'b1;
    end else begin
      ent = q.pop_front(); mdl_ready = ent[3];
    end
    exp_v = {ent, mdl_ready, mdl_ready};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(0, 4'b0);
    #3;
    total++;
    if (obs_v !== 8'b0) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs_v, 8'b0); end
    @(posedge clk); #1;
    rst_n = 1'b1; mdl_ready = 1'b1;
    #1;
    total++;
    if (obs_v !== 8'b00000011) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs_v, 8'b00000011); end
    step();
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL reset_idle got=%b exp=%b", obs_v, exp_v); end
  endtask

  task automatic test_basic(input logic [W-1:0] w);
    drive(1, w);
    step();
    drive(0, 4'($urandom));
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL basic_accept w=%b got=%b exp=%b", w, obs_v, exp_v); end
    for (int c = 1; c <= FL + 2; c++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL basic w=%b cyc=%0d got=%b exp=%b", w, c, obs_v, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 4'b1100);
    for (int c = 0; c <= FL + 1; c++) begin
      step();
      i = 4'($urandom);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL b2b_first cyc=%0d got=%b exp=%b", c, obs_v, exp_v); end
    end
    total++;
    if (done_m !== 1'b1 || ready_m !== 1'b1) begin
      bad++; $display("FAIL b2b_done_ready got=%b%b exp=11", done_m, ready_m);
    end
    i = 4'b0011;
    for (int c = 0; c <= FL + 2; c++) begin
      step();
      drive(0, 4'($urandom));
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL b2b_second cyc=%0d got=%b exp=%b", c, obs_v, exp_v); end
    end
  endtask

  task automatic test_ignore_busy();
    drive(1, 4'b1011);
    step();
    drive(0, 4'b0);
    for (int c = 1; c <= FL + 6; c++) begin
      if (c == 2) drive(1, 4'b0000);
      step();
      drive(0, 4'b0);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL ignore cyc=%0d got=%b exp=%b", c, obs_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 4'b1111);
    step();
    drive(0, 4'b0);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); mdl_ready = 1'b0;
    total++;
    if (obs_v !== 8'b0) begin bad++; $display("FAIL midreset_async got=%b exp=%b", obs_v, 8'b0); end
    for (int c = 0; c < FL + 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (obs_v !== 8'b0) begin bad++; $display("FAIL midreset_hold cyc=%0d got=%b exp=%b", c, obs_v, 8'b0); end
    end
    rst_n = 1'b1; mdl_ready = 1'b1;
    #1;
    total++;
    if (obs_v !== 8'b00000011) begin bad++; $display("FAIL midreset_release got=%b exp=%b", obs_v, 8'b00000011); end
    test_basic(4'b0101);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 2) != 0), 4'($urandom));
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, obs_v, exp_v); end
    end
    drive(0, 4'b0);
    for (int c = 0; c < FL + 3; c++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL random_drain cyc=%0d got=%b exp=%b", c, obs_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic(4'b1010);
    test_basic(4'b1000);
    test_basic(4'b1011);
    test_basic(4'b1111);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
